// File: rtl/acc_seq_pkg.sv
// Shared types and default sizing for the dot-product accumulate sequencer.
package acc_seq_pkg;

  localparam int unsigned K_DEF        = 9;
  localparam int unsigned ACC_LAT_DEF  = 2;
  localparam int unsigned NORM_LAT_DEF = 2;
  localparam int unsigned VLD_W_DEF    = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_RDY,
    S_NORM,
    S_DONE
  } state_t;

endpackage

// File: rtl/acc_seq_ctrl.sv
// Sequencer for one dot-product job: collect K terms, drain the adder pipe,
// normalize, then hold the result until the consumer takes it.
module acc_seq_ctrl
  import acc_seq_pkg::*;
#(
  parameter int unsigned K        = K_DEF,
  parameter int unsigned ACC_LAT  = ACC_LAT_DEF,
  parameter int unsigned NORM_LAT = NORM_LAT_DEF,
  parameter int unsigned VLD_W    = VLD_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     in_vld_i,
  output logic                     in_rdy_o,
  output logic                     acc_clr_o,
  output logic                     acc_en_o,
  output logic                     acc_rdy_o,
  output logic [VLD_W-1:0]         vld_d_o,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic                     busy_o,
  output logic [$clog2(K+1)-1:0]   term_cnt_o,
  output logic                     err_o
);

  localparam int unsigned CNT_W   = $clog2(K + 1);
  localparam int unsigned LAT_MAX = (ACC_LAT > NORM_LAT) ? ACC_LAT : NORM_LAT;
  localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               clr_d, in_rdy_d, acc_rdy_d, out_vld_d, busy_d, err_d;

  // Accept strobe is the registered ready window gated by the live valid
  assign acc_en_o = in_rdy_o & in_vld_i;

  // Next-state, shared latency counter and next values of registered outputs
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = term_cnt_o;
    clr_d   = 1'b0;
    err_d   = start_i && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ACCUM;
          cnt_d   = '0;
          clr_d   = 1'b1;
        end
      end
      S_ACCUM: begin
        if (in_vld_i) begin
          if (term_cnt_o == CNT_W'(K - 1)) begin
            cnt_d   = CNT_W'(K);
            state_d = S_DRAIN;
            lat_d   = LAT_W'(ACC_LAT - 1);
          end else begin
            cnt_d = term_cnt_o + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (lat_q == '0) state_d = S_RDY;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      S_RDY: begin
        state_d = S_NORM;
        lat_d   = LAT_W'(NORM_LAT - 1);
      end
      S_NORM: begin
        if (lat_q == '0) state_d = S_DONE;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      S_DONE: begin
        if (out_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_rdy_d  = (state_d == S_ACCUM);
    acc_rdy_d = (state_d == S_RDY);
    out_vld_d = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  // State register with all registered outputs
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      term_cnt_o <= '0;
      acc_clr_o  <= 1'b0;
      in_rdy_o   <= 1'b0;
      acc_rdy_o  <= 1'b0;
      out_vld_o  <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
      vld_d_o    <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      term_cnt_o <= cnt_d;
      acc_clr_o  <= clr_d;
      in_rdy_o   <= in_rdy_d;
      acc_rdy_o  <= acc_rdy_d;
      out_vld_o  <= out_vld_d;
      busy_o     <= busy_d;
      err_o      <= err_d;
      vld_d_o    <= {vld_d_o[VLD_W-2:0], busy_o};
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: stimulus queues expected pulse cycles,
// a negedge monitor pops them as the DUT raises clr/rdy/out_vld/err.
module tb_acc_seq_ctrl;

  localparam int unsigned K_T    = 9;
  localparam int unsigned ACC_T  = 2;
  localparam int unsigned NORM_T = 2;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        start_i, in_vld_i, out_rdy_i;
  logic        in_rdy_o, acc_clr_o, acc_en_o, acc_rdy_o, out_vld_o, busy_o, err_o;
  logic [11:0] vld_d_o;
  logic [3:0]  term_cnt_o;

  logic        start1, vld1, ordy1;
  logic        in_rdy1, clr1, en1, ardy1, ovld1, busy1, err1;
  logic [11:0] vldd1;
  logic [0:0]  cnt1;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int q_clr[$], q_rdy[$], q_ovld[$], q_err[$];
  int e_mon;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  acc_seq_ctrl #(.K(K_T), .ACC_LAT(ACC_T), .NORM_LAT(NORM_T), .VLD_W(12)) dut (
    .clk_i(clk_i), .rst(rst), .start_i(start_i), .in_vld_i(in_vld_i),
    .in_rdy_o(in_rdy_o), .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o),
    .acc_rdy_o(acc_rdy_o), .vld_d_o(vld_d_o), .out_vld_o(out_vld_o),
    .out_rdy_i(out_rdy_i), .busy_o(busy_o), .term_cnt_o(term_cnt_o), .err_o(err_o)
  );

  acc_seq_ctrl #(.K(1), .ACC_LAT(ACC_T), .NORM_LAT(NORM_T), .VLD_W(12)) dut1 (
    .clk_i(clk_i), .rst(rst), .start_i(start1), .in_vld_i(vld1),
    .in_rdy_o(in_rdy1), .acc_clr_o(clr1), .acc_en_o(en1),
    .acc_rdy_o(ardy1), .vld_d_o(vldd1), .out_vld_o(ovld1),
    .out_rdy_i(ordy1), .busy_o(busy1), .term_cnt_o(cnt1), .err_o(err1)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic sb(input string nm, input int e);
    total++;
    if (e < 0) begin
      bad++;
      $display("FAIL %s: pulse at cycle %0d, none required", nm, cyc);
    end else if (e != cyc) begin
      bad++;
      $display("FAIL %s: pulse at cycle %0d, required cycle %0d", nm, cyc, e);
    end
  endtask

  // Monitor: every pulse cycle must match the head of its expectation queue
  always @(negedge clk_i) begin
    if (acc_clr_o) begin
      e_mon = -1;
      if (q_clr.size() > 0) e_mon = q_clr.pop_front();
      sb("acc_clr", e_mon);
    end
    if (acc_rdy_o) begin
      e_mon = -1;
      if (q_rdy.size() > 0) e_mon = q_rdy.pop_front();
      sb("acc_rdy", e_mon);
    end
    if (out_vld_o) begin
      e_mon = -1;
      if (q_ovld.size() > 0) e_mon = q_ovld.pop_front();
      sb("out_vld", e_mon);
    end
    if (err_o) begin
      e_mon = -1;
      if (q_err.size() > 0) e_mon = q_err.pop_front();
      sb("err", e_mon);
    end
  end

  task automatic run_job(input bit toggle, input int bp, input bit glitch);
    int c0, acc_cyc, d, exp_cnt;
    bit v;
    acc_cyc = toggle ? (2 * K_T - 1) : K_T;
    d = acc_cyc + ACC_T + NORM_T + 2;
    @(posedge clk_i); #1;
    c0 = cyc;
    start_i = 1'b1;
    out_rdy_i = 1'b0;
    q_clr.push_back(c0 + 1);
    q_rdy.push_back(c0 + acc_cyc + ACC_T + 1);
    for (int i = 0; i <= bp; i++) q_ovld.push_back(c0 + d + i);
    exp_cnt = 0;
    for (int n = 1; n <= acc_cyc; n++) begin
      @(posedge clk_i); #1;
      start_i = glitch && (n == 5);
      if (start_i) q_err.push_back(c0 + n + 1);
      v = toggle ? ((n % 2) == 1) : 1'b1;
      in_vld_i = v;
      #1;
      chk("term_cnt", 32'(term_cnt_o), 32'(exp_cnt));
      chk("acc_en", 32'(acc_en_o), 32'(v));
      if (v) exp_cnt++;
    end
    for (int n = acc_cyc + 1; n <= d + bp + 13; n++) begin
      @(posedge clk_i); #1;
      in_vld_i  = (bp != 0) && (n <= d + bp);
      out_rdy_i = (n == d + bp);
      start_i   = glitch && (n == d + bp);
      if (start_i) q_err.push_back(c0 + n + 1);
      #1;
      if (n <= d + bp) chk("no_accept", 32'({in_rdy_o, acc_en_o}), 32'd0);
      if (n == acc_cyc + 1) chk("term_cnt_final", 32'(term_cnt_o), 32'(K_T));
      if (n >= d && n <= d + bp) chk("busy_done", 32'({busy_o, vld_d_o[0]}), 32'd3);
      if (n == d + bp + 1 || n == d + bp + 2) chk("idle_after", 32'(busy_o), 32'd0);
      if (n == d + bp + 12) chk("vld_d_tail", 32'(vld_d_o), 32'h800);
      if (n == d + bp + 13) chk("vld_d_zero", 32'(vld_d_o), 32'd0);
    end
    in_vld_i = 1'b0; out_rdy_i = 1'b0; start_i = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1; start_i = 1'b0; in_vld_i = 1'b0; out_rdy_i = 1'b0;
    start1 = 1'b0; vld1 = 1'b0; ordy1 = 1'b1;
    #2;
    chk("reset_outs", 32'({acc_clr_o, acc_en_o, in_rdy_o, acc_rdy_o, out_vld_o,
                           busy_o, err_o, term_cnt_o, vld_d_o}), 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst = 1'b0;

    run_job(1'b0, 0, 1'b0);   // back-to-back
    run_job(1'b1, 0, 1'b0);   // alternating valid
    run_job(1'b0, 5, 1'b0);   // 5 cycles of backpressure
    run_job(1'b0, 0, 1'b1);   // start while busy

    // Reset in the first DRAIN cycle abandons the job
    @(posedge clk_i); #1;
    c0 = cyc;
    start_i = 1'b1;
    q_clr.push_back(c0 + 1);
    for (int n = 1; n <= int'(K_T) + 1; n++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      in_vld_i = (n <= int'(K_T));
    end
    rst = 1'b1;
    #1;
    chk("rst_async", 32'({acc_clr_o, acc_en_o, in_rdy_o, acc_rdy_o, out_vld_o,
                          busy_o, err_o, term_cnt_o, vld_d_o}), 32'd0);
    @(posedge clk_i); #1;
    chk("rst_edge", 32'({acc_clr_o, acc_en_o, in_rdy_o, acc_rdy_o, out_vld_o,
                         busy_o, err_o, term_cnt_o, vld_d_o}), 32'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk_i);
    #1 chk("rst_stays_idle", 32'({busy_o, vld_d_o}), 32'd0);

    // Single-term job on the K=1 instance
    @(posedge clk_i); #1;
    start1 = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk_i); #1;
      start1 = 1'b0;
      vld1 = (n == 1);
      #1;
      if (n == 1) chk("k1_en", 32'(en1), 32'd1);
      if (n == 2) chk("k1_cnt", 32'({in_rdy1, cnt1}), 32'd1);
      chk("k1_acc_rdy", 32'(ardy1), 32'(n == 4));
      chk("k1_out_vld", 32'(ovld1), 32'(n == 7));
    end
    vld1 = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    chk("left_clr", 32'(q_clr.size()), 32'd0);
    chk("left_rdy", 32'(q_rdy.size()), 32'd0);
    chk("left_ovld", 32'(q_ovld.size()), 32'd0);
    chk("left_err", 32'(q_err.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

Interface
REQ-001 Parameter K, default 9, number of product terms per dot-product job.
REQ-002 Parameter ACC_LAT, default 2, accumulator adder pipeline depth in cycles, legal range 1 to 4.
REQ-003 Parameter NORM_LAT, default 2, scale-factor/mantissa stage latency in cycles, legal range 1 to 4.
REQ-004 Parameter VLD_W, default 12, width of the valid-delay vector.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports listed as follows:
- clk_i in 1: clock.
- rst in 1: asynchronous, active-high reset.
- start_i in 1: job start request.
- in_vld_i in 1: product term valid.
- in_rdy_o out 1: product term accepted.
- acc_clr_o out 1: clear accumulators.
- acc_en_o out 1: accumulate enable.
- acc_rdy_o out 1: accumulator result complete; normalize now.
- vld_d_o out VLD_W: pipeline activity vector to downstream stages.
- out_vld_o out 1: normalized result valid.
- out_rdy_i in 1: consumer ready.
- busy_o out 1: job in progress.
- term_cnt_o out $clog2(K+1): terms accepted so far.
- err_o out 1: start request rejected.

Function
REQ-006 FSM states SHALL be IDLE, ACCUM, DRAIN, RDY, NORM and DONE, one-hot or binary encoded.
REQ-007 IDLE: on start_i=1, go to ACCUM, pulse acc_clr_o for exactly one cycle (the IDLE sampling cycle, registered into the first ACCUM cycle), and clear term_cnt_o to 0.
REQ-008 ACCUM: in_rdy_o=1 and acc_en_o=in_vld_i; each cycle with in_vld_i=1 increments term_cnt_o by 1; in_vld_i gaps stall without state change.
REQ-009 ACCUM: accepting term K (term_cnt_o reaching K) SHALL move to DRAIN the next cycle; term_cnt_o saturates at K.
REQ-010 in_rdy_o and acc_en_o SHALL be 0 in every state except ACCUM; in_vld_i outside ACCUM is ignored.
REQ-011 DRAIN SHALL last exactly ACC_LAT cycles, counted by a latency down-counter, then go to RDY.
REQ-012 RDY SHALL last one cycle, with acc_rdy_o=1 only in that cycle, then go to NORM.
REQ-013 NORM SHALL last exactly NORM_LAT cycles, then go to DONE.
REQ-014 DONE: out_vld_o=1, held stable until out_rdy_i=1; the handshake cycle returns to IDLE next cycle.
REQ-015 Timing with back-to-back terms and start sampled at cycle 0:
- ACCUM occupies cycles 1..K.
- acc_rdy_o is high in cycle K+ACC_LAT+1.
- out_vld_o is first high in cycle K+ACC_LAT+NORM_LAT+2.
REQ-016 busy_o SHALL be 1 in every state except IDLE.
REQ-017 vld_d_o SHALL shift left each cycle with busy_o inserted at bit 0: vld_d_o <= {vld_d_o[VLD_W-2:0], busy_o}.
REQ-018 vld_d_o therefore decays to zero VLD_W cycles after returning to IDLE, which keeps downstream results alive through that window.
REQ-019 A start_i=1 sampled in any state other than IDLE SHALL be ignored and pulse err_o for one cycle, including a start in the DONE handshake cycle.
REQ-020 With K=1, a single accepted term SHALL move ACCUM to DRAIN.
REQ-021 out_rdy_i=1 in the first DONE cycle SHALL complete the transfer in that cycle, so out_vld_o is high for exactly one cycle.

Reset
REQ-022 On rst=1, state SHALL be IDLE, with the following outputs at 0: vld_d_o, term_cnt_o, the latency counter, acc_clr_o, acc_rdy_o, out_vld_o, err_o and busy_o.
REQ-023 Reset asserted mid-job SHALL abandon the job immediately, with no acc_rdy_o or out_vld_o pulse after rst deasserts.

Structure
REQ-024 Package acc_seq_pkg SHALL hold the state enum and the default values of K, ACC_LAT, NORM_LAT and VLD_W.
REQ-025 There SHALL be no sub-module; one shared latency down-counter of width $clog2(max(ACC_LAT,NORM_LAT)+1) serves both DRAIN and NORM.

Verification
REQ-026 Back-to-back run, K=9, ACC_LAT=2, NORM_LAT=2, out_rdy_i=1, start at cycle 0: acc_clr_o high in cycle 1, acc_rdy_o high in cycle 12 only, out_vld_o high in cycle 15 only, vld_d_o all-zero by cycle 28.
REQ-027 in_vld_i toggling 1,0,1,0 during ACCUM: term_cnt_o reaches 9 after 17 ACCUM cycles; acc_en_o mirrors in_vld_i exactly.
REQ-028 Backpressure, out_rdy_i=0 for 5 DONE cycles then 1: out_vld_o stays high 6 cycles; busy_o and vld_d_o[0] stay 1 throughout.
REQ-029 start_i pulsed in cycle 5 (ACCUM) and in the DONE handshake cycle: err_o pulses one cycle each; job timing unchanged; no restart occurs.
REQ-030 rst asserted in the DRAIN cycle: all outputs read 0 next edge; after release with no start, acc_rdy_o and out_vld_o never assert.
REQ-031 K=1, single term: acc_rdy_o high in cycle 4; out_vld_o high in cycle 7.
